// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic valid/ready pipeline stage register with optional skid entry
// One FSM serves both builds; with SKID=0 the SKID state is never entered and in_ready looks at out_ready.
module pipe_stage_elastic #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 3,
    parameter int RD_W   = 4,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [CTRL_W-1:0] i_in_ctrl,
    input  logic [RD_W-1:0]   i_in_rd,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [CTRL_W-1:0] o_out_ctrl,
    output logic [RD_W-1:0]   o_out_rd,
    output logic [DATA_W-1:0] o_out_data,
    output logic [1:0]        o_occupancy
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [RD_W-1:0]     r_main_rd;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [RD_W-1:0]     r_skid_rd;
    logic [DATA_W-1:0]   r_skid_data;
    logic                w_accept;
    logic                w_drain;
    logic                w_load_main;
    logic                w_main_from_skid;
    logic                w_load_skid;

    assign o_out_valid = (r_state != S_EMPTY);
    assign w_accept    = i_in_valid & o_in_ready;
    assign w_drain     = o_out_valid & i_out_ready;

    // SKID=1 keeps in_ready purely registered so out_ready never reaches upstream combinationally.
    always_comb begin
        if (SKID != 0) o_in_ready = (r_state != S_SKID);
        else           o_in_ready = (r_state == S_EMPTY) | i_out_ready;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_load_main = 1'b1;
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (w_accept && w_drain) begin
                    w_load_main = 1'b1;
                end else if (w_drain) begin
                    w_state_nxt = S_EMPTY;
                end else if (w_accept && (SKID != 0)) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = S_SKID;
                end
            end
            S_SKID: begin
                if (w_drain) begin
                    w_main_from_skid = 1'b1;
                    w_state_nxt      = S_FULL;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        // Flush wins over everything; payload registers are left untouched.
        if (i_flush) begin
            w_state_nxt      = S_EMPTY;
            w_load_main      = 1'b0;
            w_main_from_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_EMPTY;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_ctrl <= '0;
            r_main_rd   <= '0;
            r_main_data <= '0;
        end else if (w_load_main) begin
            r_main_ctrl <= i_in_ctrl;
            r_main_rd   <= i_in_rd;
            r_main_data <= i_in_data;
        end else if (w_main_from_skid) begin
            r_main_ctrl <= r_skid_ctrl;
            r_main_rd   <= r_skid_rd;
            r_main_data <= r_skid_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skid_ctrl <= '0;
            r_skid_rd   <= '0;
            r_skid_data <= '0;
        end else if (w_load_skid) begin
            r_skid_ctrl <= i_in_ctrl;
            r_skid_rd   <= i_in_rd;
            r_skid_data <= i_in_data;
        end
    end

    assign o_out_ctrl  = o_out_valid ? r_main_ctrl : '0;
    assign o_out_rd    = r_main_rd;
    assign o_out_data  = r_main_data;

    always_comb begin
        case (r_state)
            S_FULL:  o_occupancy = 2'd1;
            S_SKID:  o_occupancy = 2'd2;
            default: o_occupancy = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - bench for pipe_stage_elastic, SKID=1 (index 1) and SKID=0 (index 0) side by side
// A queue per instance holds the words that must still come out, in order.
module tb_pipe_stage_elastic;

    localparam int EW = 3 + 4 + 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        fl[2], iv[2], ordy[2], ov[2], irdy[2];
    logic [2:0]  ictl[2], octl[2];
    logic [3:0]  ird[2], ord_o[2];
    logic [63:0] idat[2], odat[2];
    logic [1:0]  occ[2];

    int checks = 0;
    int failures = 0;

    logic [EW-1:0] mq[2][$];

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(64), .CTRL_W(3), .RD_W(4), .SKID(1)) u_s1 (
        .clk(clk), .reset(reset), .i_flush(fl[1]), .i_in_valid(iv[1]), .o_in_ready(irdy[1]),
        .i_in_ctrl(ictl[1]), .i_in_rd(ird[1]), .i_in_data(idat[1]), .o_out_valid(ov[1]),
        .i_out_ready(ordy[1]), .o_out_ctrl(octl[1]), .o_out_rd(ord_o[1]), .o_out_data(odat[1]),
        .o_occupancy(occ[1])
    );

    pipe_stage_elastic #(.DATA_W(64), .CTRL_W(3), .RD_W(4), .SKID(0)) u_s0 (
        .clk(clk), .reset(reset), .i_flush(fl[0]), .i_in_valid(iv[0]), .o_in_ready(irdy[0]),
        .i_in_ctrl(ictl[0]), .i_in_rd(ird[0]), .i_in_data(idat[0]), .o_out_valid(ov[0]),
        .i_out_ready(ordy[0]), .o_out_ctrl(octl[0]), .o_out_rd(ord_o[0]), .o_out_data(odat[0]),
        .o_occupancy(occ[0])
    );

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s skid=%0d actual=%0h required=%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Capacity rule: two words with a skid entry; one word that may be replaced while draining without.
    function automatic logic exp_ready(input int k);
        if (k == 1) return mq[k].size() < 2;
        return (mq[k].size() == 0) || ordy[k];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq[0].delete();
            mq[1].delete();
        end else begin
            for (int k = 0; k < 2; k++) begin
                automatic logic acc = iv[k] & exp_ready(k);
                automatic logic drn = (mq[k].size() > 0) && ordy[k];
                if (fl[k]) mq[k].delete();
                else begin
                    if (drn) void'(mq[k].pop_front());
                    if (acc) mq[k].push_back({ictl[k], ird[k], idat[k]});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                chk("m_valid", k, 64'(ov[k]), 64'(mq[k].size() > 0));
                chk("m_occ", k, 64'(occ[k]), 64'(mq[k].size()));
                chk("m_ready", k, 64'(irdy[k]), 64'(exp_ready(k)));
                if (mq[k].size() > 0) begin
                    chk("m_ctrl", k, 64'(octl[k]), 64'(mq[k][0][EW-1 -: 3]));
                    chk("m_rd", k, 64'(ord_o[k]), 64'(mq[k][0][67:64]));
                    chk("m_data", k, odat[k], mq[k][0][63:0]);
                end else begin
                    chk("m_ctrl_idle", k, 64'(octl[k]), 64'd0);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic r, input logic f, input logic [2:0] c,
                         input logic [3:0] rd, input logic [63:0] d);
        for (int k = 0; k < 2; k++) begin
            iv[k] = v; ordy[k] = r; fl[k] = f; ictl[k] = c; ird[k] = rd; idat[k] = d;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_valid"}, k, 64'(ov[k]), 64'd0);
            chk({tag, "_ctrl"}, k, 64'(octl[k]), 64'd0);
            chk({tag, "_rd"}, k, 64'(ord_o[k]), 64'd0);
            chk({tag, "_data"}, k, odat[k], 64'd0);
            chk({tag, "_occ"}, k, 64'(occ[k]), 64'd0);
            chk({tag, "_ready"}, k, 64'(irdy[k]), 64'd1);
        end
    endtask

    task automatic stream(input int base, input string tag);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 1'b0, 3'b001, 4'(i), 64'(base + i));
            step();
            for (int k = 0; k < 2; k++) begin
                chk({tag, "_data"}, k, odat[k], 64'(base + i));
                chk({tag, "_occ"}, k, 64'(occ[k]), 64'd1);
            end
        end
        drive(1'b0, 1'b1, 1'b0, 3'b000, 4'h0, 64'd0);
        step();
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 4'h0, 64'd0);
        #2;
        chk_reset_vals("rst");
        step();
        step();
        reset = 1'b0;
        step();

        // T1 streaming
        stream(1, "t1");

        // T2 skid capture of 0xBEEF behind 0xAAAA
        drive(1'b1, 1'b1, 1'b0, 3'b011, 4'h1, 64'hAAAA);
        step();
        drive(1'b1, 1'b0, 1'b0, 3'b011, 4'h2, 64'hBEEF);
        step();
        chk("t2_occ", 1, 64'(occ[1]), 64'd2);
        chk("t2_ready", 1, 64'(irdy[1]), 64'd0);
        chk("t2_occ", 0, 64'(occ[0]), 64'd1);
        drive(1'b0, 1'b1, 1'b0, 3'b000, 4'h0, 64'd0);
        chk("t2_first", 1, odat[1], 64'hAAAA);
        step();
        chk("t2_second", 1, odat[1], 64'hBEEF);
        step();

        // T3 long stall holding 0x1234 / ctrl 101
        drive(1'b1, 1'b1, 1'b0, 3'b101, 4'h7, 64'h1234);
        step();
        drive(1'b1, 1'b0, 1'b0, 3'b010, 4'h2, 64'h5678);
        for (int n = 0; n < 20; n++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                chk("t3_data", k, odat[k], 64'h1234);
                chk("t3_ctrl", k, 64'(octl[k]), 64'h5);
                chk("t3_ready", k, 64'(irdy[k]), 64'd0);
            end
        end
        drive(1'b0, 1'b1, 1'b0, 3'b000, 4'h0, 64'd0);
        step();
        chk("t3_skidword", 1, odat[1], 64'h5678);
        chk("t3_skidctrl", 1, 64'(octl[1]), 64'h2);
        chk("t3_drained", 0, 64'(ov[0]), 64'd0);
        step();

        // T4 flush with two held words and a same-cycle offer
        drive(1'b1, 1'b1, 1'b0, 3'b111, 4'h3, 64'h11);
        step();
        drive(1'b1, 1'b0, 1'b0, 3'b111, 4'h4, 64'h22);
        step();
        chk("t4_pre_occ", 1, 64'(occ[1]), 64'd2);
        drive(1'b1, 1'b1, 1'b1, 3'b111, 4'h5, 64'h33);
        step();
        for (int k = 0; k < 2; k++) begin
            chk("t4_valid", k, 64'(ov[k]), 64'd0);
            chk("t4_ctrl", k, 64'(octl[k]), 64'd0);
            chk("t4_occ", k, 64'(occ[k]), 64'd0);
            chk("t4_ready", k, 64'(irdy[k]), 64'd1);
        end
        drive(1'b0, 1'b1, 1'b0, 3'b000, 4'h0, 64'd0);
        step();

        // T5 asynchronous reset while the skid entry is occupied
        drive(1'b1, 1'b1, 1'b0, 3'b110, 4'h6, 64'h44);
        step();
        drive(1'b1, 1'b0, 1'b0, 3'b110, 4'h6, 64'h55);
        step();
        chk("t5_pre_occ", 1, 64'(occ[1]), 64'd2);
        #2 reset = 1'b1;
        #1;
        chk_reset_vals("t5");
        drive(1'b0, 1'b0, 1'b0, 3'b000, 4'h0, 64'd0);
        step();
        reset = 1'b0;
        stream(32'h100, "t5s");

        // Random valid/ready/flush traffic, each instance independent
        for (int n = 0; n < 10000; n++) begin
            for (int k = 0; k < 2; k++) begin
                iv[k]   = ($urandom_range(0, 3) != 0);
                ordy[k] = ($urandom_range(0, 2) != 0);
                fl[k]   = ($urandom_range(0, 63) == 0);
                ictl[k] = 3'($urandom);
                ird[k]  = 4'($urandom);
                idat[k] = {$urandom, $urandom};
            end
            step();
        end

        drive(1'b0, 1'b1, 1'b0, 3'b000, 4'h0, 64'd0);
        step();
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
